// File: rtl/seg7_mux_ctrl_if.sv
// CPU register-bus view of the 7-segment controller: select, direction, index, write and read data.
interface seg7_mux_ctrl_if;
  logic       cs;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, rw, addr, din, input dout);
  modport slave  (input cs, rw, addr, din, output dout);
endinterface

// File: rtl/seg7_mux_ctrl.sv
// Two-digit multiplexed 7-segment controller with hex/raw modes, blanking, blink and anti-ghost dead-time.
// Optional SEG_BRIGHTNESS_EN adds a 3-bit PWM brightness field in CTRL[7:5].
module seg7_mux_ctrl #(
  parameter int CLK_HZ            = 6000000,
  parameter int REFRESH_HZ        = 50,
  parameter int BLANK_CYCLES      = 16,
  parameter int BLINK_SLOTS       = 50,
  parameter int SEG_ACTIVE_LOW    = 0,
  parameter int ANODE_ACTIVE_HIGH = 1
) (
  input  logic             sys_clk,
  input  logic             sys_res,
  seg7_mux_ctrl_if.slave   bus,
  output logic [8:0]       seg_led_h,
  output logic [8:0]       seg_led_l
);

  localparam int DIV      = CLK_HZ / (REFRESH_HZ * 2);
  localparam int SHOW_LEN = DIV - BLANK_CYCLES;
  localparam int CW       = $clog2(DIV);
  localparam int BW       = $clog2(BLINK_SLOTS + 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_ON   = (ANODE_ACTIVE_HIGH != 0);
`ifdef SEG_BRIGHTNESS_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'h1F;
`endif

  typedef enum logic [1:0] {SHOW_L, GAP_LH, SHOW_H, GAP_HL} state_t;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_nxt;
  logic            phase_q, phase_nxt;
  logic [7:0]      pat_q, pat_nxt;
  logic [7:0]      data_q, ctrl_q, raw_h_q, raw_l_q;
  logic            entering, digit_h, lit;
  logic [3:0]      nib;
  logic [7:0]      seg_h_nxt, seg_l_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_ff @(posedge sys_clk or posedge sys_res) begin
    if (sys_res) begin
      data_q  <= 8'h00;
      ctrl_q  <= 8'h00;
      raw_h_q <= 8'h00;
      raw_l_q <= 8'h00;
    end else if (bus.cs && !bus.rw) begin
      case (bus.addr)
        2'd0:    data_q  <= bus.din;
        2'd1:    ctrl_q  <= bus.din & CTRL_MASK;
        2'd2:    raw_h_q <= bus.din;
        default: raw_l_q <= bus.din;
      endcase
    end
  end

  always_comb begin
    bus.dout = 8'h00;
    if (bus.cs && bus.rw) begin
      case (bus.addr)
        2'd0:    bus.dout = data_q;
        2'd1:    bus.dout = ctrl_q;
        2'd2:    bus.dout = raw_h_q;
        default: bus.dout = raw_l_q;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q + 1'b1;
    blink_cnt_nxt = blink_cnt_q;
    phase_nxt     = phase_q;
    entering      = 1'b0;
    case (state_q)
      SHOW_L: if (cnt_q == CW'(SHOW_LEN - 1)) state_nxt = GAP_LH;
      SHOW_H: if (cnt_q == CW'(SHOW_LEN - 1)) state_nxt = GAP_HL;
      GAP_LH: if (cnt_q == CW'(DIV - 1)) begin
        state_nxt = SHOW_H;
        cnt_nxt   = '0;
        entering  = 1'b1;
      end
      default: if (cnt_q == CW'(DIV - 1)) begin
        state_nxt = SHOW_L;
        cnt_nxt   = '0;
        entering  = 1'b1;
        if (blink_cnt_q == BW'(BLINK_SLOTS - 1)) begin
          blink_cnt_nxt = '0;
          phase_nxt     = ~phase_q;
        end else begin
          blink_cnt_nxt = blink_cnt_q + 1'b1;
        end
      end
    endcase

    // Pattern is latched from pre-write registers; blink uses the phase of the slot being entered.
    digit_h = (state_q == GAP_LH);
    nib     = digit_h ? data_q[7:4] : data_q[3:0];
    pat_nxt = pat_q;
    if (entering) begin
      if (ctrl_q[1] || (ctrl_q[4] && !phase_nxt))
        pat_nxt = 8'h00;
      else if (ctrl_q[0])
        pat_nxt = digit_h ? raw_h_q : raw_l_q;
      else
        pat_nxt = {(digit_h ? ctrl_q[2] : ctrl_q[3]), hex7(nib)};
    end

`ifdef SEG_BRIGHTNESS_EN
    lit = (int'(cnt_nxt) < (((int'(ctrl_q[7:5]) + 1) * SHOW_LEN) >> 3));
`else
    lit = 1'b1;
`endif
    seg_l_nxt = (state_nxt == SHOW_L && lit) ? pat_nxt : 8'h00;
    seg_h_nxt = (state_nxt == SHOW_H && lit) ? pat_nxt : 8'h00;
  end

  always_ff @(posedge sys_clk or posedge sys_res) begin
    if (sys_res) begin
      state_q     <= SHOW_L;
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pat_q       <= 8'h00;
      seg_led_l   <= {AN_ON, {8{SEG_INV}}};
      seg_led_h   <= {~AN_ON, {8{SEG_INV}}};
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      blink_cnt_q <= blink_cnt_nxt;
      phase_q     <= phase_nxt;
      pat_q       <= pat_nxt;
      seg_led_l   <= {((state_nxt == SHOW_L) ? AN_ON : ~AN_ON), seg_l_nxt ^ {8{SEG_INV}}};
      seg_led_h   <= {((state_nxt == SHOW_H) ? AN_ON : ~AN_ON), seg_h_nxt ^ {8{SEG_INV}}};
    end
  end

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Randomized + directed bench for seg7_mux_ctrl; expected outputs come from a slot-timeline model.
module tb_seg7_mux_ctrl;
  localparam int DIV   = 10;
  localparam int SHOW  = 8;
  localparam int BSLOT = 2;
`ifdef SEG_BRIGHTNESS_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = 8'h1F;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_res;
  logic [8:0] seg_led_h, seg_led_l;
  seg7_mux_ctrl_if bus ();

  seg7_mux_ctrl #(
    .CLK_HZ(1000), .REFRESH_HZ(50), .BLANK_CYCLES(2), .BLINK_SLOTS(BSLOT),
    .SEG_ACTIVE_LOW(0), .ANODE_ACTIVE_HIGH(1)
  ) dut (
    .sys_clk(sys_clk), .sys_res(sys_res), .bus(bus.slave),
    .seg_led_h(seg_led_h), .seg_led_l(seg_led_l)
  );

  always #5 sys_clk = ~sys_clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0] m_regs [4];
  logic [7:0] m_pat;
  int         t;
  int         vecs = 0;
  int         errs = 0;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t     = 0;
    m_pat = 8'h00;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
  endtask

  // One clock: drive bus, check a read, advance the model one cycle, compare both digit outputs.
  task automatic step(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
    logic [7:0] pre [4];
    logic [7:0] c, exp_seg;
    int s, p, k;
    bit hi, phase_on, show, lit;
    bus.cs = cs; bus.rw = rw; bus.addr = a; bus.din = d;
    #1;
    if (cs && rw) check("dout", {1'b0, bus.dout}, {1'b0, m_regs[a]});
    pre = m_regs;
    if (cs && !rw) m_regs[a] = (a == 2'd1) ? (d & CTRL_MASK) : d;
    @(posedge sys_clk);
    t++;
    #1 bus.cs = 1'b0;
    s  = t / DIV;
    p  = t % DIV;
    hi = (s % 2) == 1;
    c  = pre[1];
    if (p == 0) begin
      k        = s / 2;
      phase_on = ((k / BSLOT) % 2) == 0;
      if (c[1] || (c[4] && !phase_on)) m_pat = 8'h00;
      else if (c[0])                   m_pat = hi ? pre[2] : pre[3];
      else m_pat = {(hi ? c[2] : c[3]), hex_tab[hi ? pre[0][7:4] : pre[0][3:0]]};
    end
    show = p < SHOW;
`ifdef SEG_BRIGHTNESS_EN
    lit = p < (((int'(c[7:5]) + 1) * SHOW) >> 3);
`else
    lit = 1'b1;
`endif
    exp_seg = (show && lit) ? m_pat : 8'h00;
    @(negedge sys_clk);
    check("seg_l", seg_led_l, {show && !hi, (show && !hi) ? exp_seg : 8'h00});
    check("seg_h", seg_led_h, {show && hi,  (show && hi)  ? exp_seg : 8'h00});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    step(1'b1, 1'b1, a, 8'h00);
  endtask

  // Advance (bounded) until the model sits at slot position wp of the requested digit.
  task automatic idle_until(input int wp, input bit want_hi);
    int n = 0;
    while (!(((t % DIV) == wp) && (((t / DIV) % 2 == 1) == want_hi)) && n < 2 * DIV) begin
      idle(1);
      n++;
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.rw = 1'b0; bus.addr = 2'd0; bus.din = 8'h00;
    sys_res = 1'b1;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check("rst_seg_l", seg_led_l, 9'h100);
    check("rst_seg_h", seg_led_h, 9'h000);
    sys_res = 1'b0;

    // Idle refresh sequence from reset
    idle(20);
    // Hex decode with both decimal points
    wr(2'd0, 8'hA5); wr(2'd1, 8'h0C);
    idle(22);
    rd(2'd0); rd(2'd1);
    // Raw mode, then a mid-slot write that must wait for the next low slot
    wr(2'd1, 8'h01); wr(2'd2, 8'h81); wr(2'd3, 8'h40);
    idle(20);
    idle_until(3, 1'b0);
    wr(2'd3, 8'h22);
    idle(25);
    // Blanking, then blink
    wr(2'd0, 8'h11); wr(2'd1, 8'h12);
    idle(30);
    wr(2'd1, 8'h10);
    idle(100);
    wr(2'd1, 8'hFF); rd(2'd1);
    // Asynchronous reset in the middle of a high-digit slot
    wr(2'd0, 8'hFF); wr(2'd1, 8'h00);
    idle(10);
    idle_until(3, 1'b1);
    #2 sys_res = 1'b1;
    #1;
    check("mid_rst_seg_l", seg_led_l, 9'h100);
    check("mid_rst_seg_h", seg_led_h, 9'h000);
    for (int a = 0; a < 4; a++) begin
      bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = 2'(a);
      #1 check("rst_read", {1'b0, bus.dout}, 9'h000);
    end
    bus.cs = 1'b0;
    @(negedge sys_clk);
    sys_res = 1'b0;
    model_reset();
    idle(12);
`ifdef SEG_BRIGHTNESS_EN
    wr(2'd1, 8'h60); wr(2'd0, 8'h88);
    idle(40);
`endif
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 15)      wr(2'($urandom_range(0, 3)), 8'($urandom));
      else if (op < 30) rd(2'($urandom_range(0, 3)));
      else              idle(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
